// File: rtl/pll_lock_supervisor.sv
// -----------------------------------------------------------------------------
// pll_lock_supervisor
//
// Sequences the reset/lock handshake of a PLL. This block drives the PLL reset
// and watches the PLL lock output. Downstream logic stays in reset until lock
// has been stable for LOCK_STABLE_CYCLES. A lock timeout or a lock loss starts
// a new attempt. After MAX_RETRIES failed attempts in a row, the block latches
// FAULT. Only the block reset clears FAULT.
//
// Optional build macro:
//   PLL_SUPERVISOR_GLITCH_FILTER_EN
//     Defined   : in RUN, lock must read low for 4 consecutive cycles before it
//                 counts as a loss. Drops of 1-3 cycles are ignored.
//     Undefined : a single low cycle of the synchronized lock in RUN counts as
//                 a loss.
//
// Ports:
//   clk          in   reference clock (also feeds the PLL input)
//   reset        in   synchronous, active-high block reset
//   pll_lock     in   PLL lock, asynchronous to clk
//   pll_reset    out  active-high PLL reset
//   sys_reset    out  active-high downstream reset, synchronous to clk
//   locked       out  high only in RUN
//   fault        out  high only in FAULT
//   retry_count  out  failed attempts since the last RUN entry (saturating)
//   lost_count   out  lock-loss events seen in RUN (saturating)
//   state        out  current FSM state
//
// state | meaning
// ------+--------------------------------------------------------------
//   0   | RESET_PLL : hold PLL in reset for RESET_CYCLES
//   1   | WAIT_LOCK : PLL released, wait for lock or timeout
//   2   | STABLE    : lock seen, require LOCK_STABLE_CYCLES of steady lock
//   3   | RUN       : downstream released, watch for lock loss
//   4   | FAULT     : too many failed attempts, wait for block reset
// -----------------------------------------------------------------------------
module pll_lock_supervisor #(
  parameter int RESET_CYCLES        = 32,
  parameter int LOCK_STABLE_CYCLES  = 2700,
  parameter int LOCK_TIMEOUT_CYCLES = 270000,
  parameter int MAX_RETRIES         = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pll_lock,
  output logic       pll_reset,
  output logic       sys_reset,
  output logic       locked,
  output logic       fault,
  output logic [7:0] retry_count,
  output logic [7:0] lost_count,
  output logic [2:0] state
);

  localparam logic [2:0] S_RESET_PLL = 3'd0;
  localparam logic [2:0] S_WAIT_LOCK = 3'd1;
  localparam logic [2:0] S_STABLE    = 3'd2;
  localparam logic [2:0] S_RUN       = 3'd3;
  localparam logic [2:0] S_FAULT     = 3'd4;

  // One shared phase counter. It only has to reach (largest parameter - 1).
  localparam int MAX_A   = (RESET_CYCLES > LOCK_STABLE_CYCLES) ?
                           RESET_CYCLES : LOCK_STABLE_CYCLES;
  localparam int MAX_CYC = (MAX_A > LOCK_TIMEOUT_CYCLES) ? MAX_A : LOCK_TIMEOUT_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] RESET_LAST   = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [7:0]       RETRY_LIMIT  = 8'(MAX_RETRIES);

  logic             lock_meta;
  logic             lock_s;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [2:0]       state_nxt;
  logic [7:0]       retry_nxt;
  logic [7:0]       lost_nxt;
  logic [7:0]       retry_inc;
  logic [7:0]       lost_inc;
  logic             lock_loss;

  assign retry_inc = (retry_count == 8'hFF) ? 8'hFF : retry_count + 8'd1;
  assign lost_inc  = (lost_count  == 8'hFF) ? 8'hFF : lost_count  + 8'd1;

`ifdef PLL_SUPERVISOR_GLITCH_FILTER_EN
  // Counts consecutive low cycles of lock_s in RUN. The loss fires on the
  // fourth low cycle. Any high cycle, or leaving RUN, clears the count.
  logic [1:0] glitch_cnt;
  logic [1:0] glitch_nxt;

  always_comb begin
    glitch_nxt = 2'd0;
    lock_loss  = 1'b0;
    if (state == S_RUN && !lock_s) begin
      if (glitch_cnt == 2'd3) begin
        lock_loss = 1'b1;
      end else begin
        glitch_nxt = glitch_cnt + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      glitch_cnt <= 2'd0;
    end else begin
      glitch_cnt <= glitch_nxt;
    end
  end
`else
  always_comb begin
    lock_loss = (state == S_RUN) && !lock_s;
  end
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CNT_ONE;
    retry_nxt = retry_count;
    lost_nxt  = lost_count;

    case (state)
      S_RESET_PLL: begin
        if (cnt == RESET_LAST) begin
          state_nxt = S_WAIT_LOCK;
          cnt_nxt   = '0;
        end
      end

      S_WAIT_LOCK: begin
        // If lock and timeout happen in the same cycle, lock wins.
        if (lock_s) begin
          state_nxt = S_STABLE;
          cnt_nxt   = '0;
        end else if (cnt == TIMEOUT_LAST) begin
          cnt_nxt   = '0;
          retry_nxt = retry_inc;
          state_nxt = (retry_inc == RETRY_LIMIT) ? S_FAULT : S_RESET_PLL;
        end
      end

      S_STABLE: begin
        // A drop during qualification does not count as a failed attempt.
        // Go back and wait with a fresh timeout.
        if (!lock_s) begin
          state_nxt = S_WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt == STABLE_LAST) begin
          state_nxt = S_RUN;
          cnt_nxt   = '0;
          retry_nxt = 8'd0;
        end
      end

      S_RUN: begin
        cnt_nxt = '0;
        if (lock_loss) begin
          state_nxt = S_RESET_PLL;
          lost_nxt  = lost_inc;
        end
      end

      S_FAULT: begin
        cnt_nxt = '0;
      end

      default: begin
        state_nxt = S_RESET_PLL;
        cnt_nxt   = '0;
      end
    endcase
  end

  // The outputs are decoded from the next state and registered with it.
  // They therefore change on the same edge as state.
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_meta   <= 1'b0;
      lock_s      <= 1'b0;
      state       <= S_RESET_PLL;
      cnt         <= '0;
      retry_count <= 8'd0;
      lost_count  <= 8'd0;
      pll_reset   <= 1'b1;
      sys_reset   <= 1'b1;
      locked      <= 1'b0;
      fault       <= 1'b0;
    end else begin
      lock_meta   <= pll_lock;
      lock_s      <= lock_meta;
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      retry_count <= retry_nxt;
      lost_count  <= lost_nxt;
      pll_reset   <= (state_nxt == S_RESET_PLL) || (state_nxt == S_FAULT);
      sys_reset   <= (state_nxt != S_RUN);
      locked      <= (state_nxt == S_RUN);
      fault       <= (state_nxt == S_FAULT);
    end
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
module tb_pll_lock_supervisor;

  localparam int RC  = 4;
  localparam int LSC = 8;
  localparam int LTC = 20;
  localparam int MR  = 2;
`ifdef PLL_SUPERVISOR_GLITCH_FILTER_EN
  localparam int LOSS_LEN = 4;
`else
  localparam int LOSS_LEN = 1;
`endif

  localparam int P_RST  = 0;
  localparam int P_WAIT = 1;
  localparam int P_STAB = 2;
  localparam int P_RUN  = 3;
  localparam int P_FLT  = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       pll_lock;
  logic       pll_reset;
  logic       sys_reset;
  logic       locked;
  logic       fault;
  logic [7:0] retry_count;
  logic [7:0] lost_count;
  logic [2:0] state;

  always #5 clk = ~clk;

  pll_lock_supervisor #(
    .RESET_CYCLES(RC),
    .LOCK_STABLE_CYCLES(LSC),
    .LOCK_TIMEOUT_CYCLES(LTC),
    .MAX_RETRIES(MR)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pll_lock(pll_lock),
    .pll_reset(pll_reset),
    .sys_reset(sys_reset),
    .locked(locked),
    .fault(fault),
    .retry_count(retry_count),
    .lost_count(lost_count),
    .state(state)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model. It tracks the phase, the time spent in the phase, and
  // the length of the current low run of lock. Lock reaches the model through
  // a two-sample delay line.
  int m_state, m_elapsed, m_retry, m_lost, m_low;
  bit m_d1, m_d2;

  task automatic model_step();
    bit ls;
    if (reset) begin
      m_state = P_RST; m_elapsed = 0; m_retry = 0; m_lost = 0; m_low = 0;
      m_d1 = 0; m_d2 = 0;
      return;
    end
    ls   = m_d2;
    m_d2 = m_d1;
    m_d1 = pll_lock;
    case (m_state)
      P_RST: begin
        m_elapsed++;
        if (m_elapsed == RC) begin m_state = P_WAIT; m_elapsed = 0; end
      end
      P_WAIT: begin
        if (ls) begin
          m_state = P_STAB; m_elapsed = 0;
        end else begin
          m_elapsed++;
          if (m_elapsed == LTC) begin
            m_retry   = (m_retry < 255) ? m_retry + 1 : 255;
            m_state   = (m_retry == MR) ? P_FLT : P_RST;
            m_elapsed = 0;
          end
        end
      end
      P_STAB: begin
        if (!ls) begin
          m_state = P_WAIT; m_elapsed = 0;
        end else begin
          m_elapsed++;
          if (m_elapsed == LSC) begin
            m_state = P_RUN; m_elapsed = 0; m_retry = 0; m_low = 0;
          end
        end
      end
      P_RUN: begin
        m_low = ls ? 0 : m_low + 1;
        if (m_low >= LOSS_LEN) begin
          m_state = P_RST; m_elapsed = 0; m_low = 0;
          m_lost  = (m_lost < 255) ? m_lost + 1 : 255;
        end
      end
      default: ;
    endcase
  endtask

  int cyc = 0;
  int pr_high = 0;
  int t_stable = -1;
  int t_sysfall = -1;
  logic [2:0] prev_state = 3'd0;
  logic       prev_sys = 1'b1;

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    cyc++;
    check_val("state", state, m_state);
    check_val("pll_reset", pll_reset, (m_state == P_RST) || (m_state == P_FLT));
    check_val("sys_reset", sys_reset, m_state != P_RUN);
    check_val("locked", locked, m_state == P_RUN);
    check_val("fault", fault, m_state == P_FLT);
    check_val("retry_count", retry_count, m_retry);
    check_val("lost_count", lost_count, m_lost);
    if (pll_reset === 1'b1) pr_high++;
    if (state == 3'd2 && prev_state != 3'd2) t_stable = cyc;
    if (sys_reset === 1'b0 && prev_sys === 1'b1) t_sysfall = cyc;
    prev_state = state;
    prev_sys   = sys_reset;
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic wait_dut_state(input string tag, input int target, input int limit);
    int k = 0;
    while (state !== 3'(target) && k < limit) begin
      cycle();
      k++;
    end
    check_val(tag, state, target);
  endtask

  task automatic reset_checks(input string pfx);
    check_val({pfx, "_state"}, state, 0);
    check_val({pfx, "_pll_reset"}, pll_reset, 1);
    check_val({pfx, "_sys_reset"}, sys_reset, 1);
    check_val({pfx, "_fault"}, fault, 0);
    check_val({pfx, "_retry"}, retry_count, 0);
    check_val({pfx, "_lost"}, lost_count, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    reset    = 1'b1;
    pll_lock = 1'b0;
    #2;

    // Reset state and normal bring-up
    pr_high = 0;
    cycle();
    reset_checks("rst");
    reset = 1'b0;
    run(5);
    pll_lock = 1'b1;
    wait_dut_state("t1_run", P_RUN, 60);
    check_val("t1_pll_reset_len", pr_high, RC);
    check_val("t1_sys_rel_delay", t_sysfall - t_stable, LSC);
    check_val("t1_locked", locked, 1);
    check_val("t1_retry", retry_count, 0);

    // Loss in RUN: a single-cycle drop, then a four-cycle drop
    run(3);
    pll_lock = 1'b0;
    cycle();
    pll_lock = 1'b1;
    run(6);
    check_val("t4_lost_1cyc", lost_count, (LOSS_LEN == 1) ? 1 : 0);
    wait_dut_state("t4_relock", P_RUN, 100);
    run(2);
    pll_lock = 1'b0;
    run(4);
    pll_lock = 1'b1;
    run(6);
    check_val("t4_lost_4cyc", lost_count, (LOSS_LEN == 1) ? 2 : 1);
    wait_dut_state("t4_relock2", P_RUN, 100);

    // Stability abort
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    wait_dut_state("t3_stable", P_STAB, 40);
    run(3);
    pll_lock = 1'b0;
    cycle();
    pll_lock = 1'b1;
    wait_dut_state("t3_abort", P_WAIT, 6);
    check_val("t3_sys_reset", sys_reset, 1);
    wait_dut_state("t3_stable2", P_STAB, 10);
    wait_dut_state("t3_run", P_RUN, 20);
    check_val("t3_stable_len", t_sysfall - t_stable, LSC);

    // Reset while in STABLE
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    wait_dut_state("t5_to_stable", P_STAB, 40);
    reset    = 1'b1;
    pll_lock = 1'b0;
    cycle();
    reset_checks("t5s");
    reset = 1'b0;

    // Timeout, retry, then fault
    wait_dut_state("t2_wait", P_WAIT, 10);
    run(LTC);
    check_val("t2_retry1", retry_count, 1);
    check_val("t2_repulse", pll_reset, 1);
    wait_dut_state("t2_fault", P_FLT, 200);
    check_val("t2_fault_flag", fault, 1);
    check_val("t2_pll_reset", pll_reset, 1);
    check_val("t2_sys_reset", sys_reset, 1);
    check_val("t2_retry2", retry_count, MR);
    pll_lock = 1'b1;
    run(30);
    check_val("t2_stuck", state, P_FLT);

    // Reset while in FAULT
    reset    = 1'b1;
    pll_lock = 1'b0;
    cycle();
    reset_checks("t5f");
    reset = 1'b0;

    // Lock arrives in the same cycle as the timeout, on the second attempt
    wait_dut_state("t6_wait1", P_WAIT, 10);
    wait_dut_state("t6_retry", P_RST, 40);
    wait_dut_state("t6_wait2", P_WAIT, 10);
    g = 0;
    while (m_elapsed != LTC - 3 && g < 40) begin
      cycle();
      g++;
    end
    check_val("t6_pre", state, P_WAIT);
    pll_lock = 1'b1;
    run(3);
    check_val("t6_state", state, P_STAB);
    check_val("t6_retry", retry_count, 1);
    wait_dut_state("t6_run", P_RUN, 20);

    // Randomized segments
    for (int s = 0; s < 200; s++) begin
      int len;
      len = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 5) : $urandom_range(1, 30);
      reset    = ($urandom_range(0, 24) == 0);
      pll_lock = ($urandom_range(0, 3) != 0);
      cycle();
      reset = 1'b0;
      run(len - 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
